// File: rtl/mod_exp_controller.sv
// mod_exp_controller: left-to-right binary square-and-multiply sequencer that
// drives one shared multiplication_modulo unit to compute base^exp mod modulus.
module mod_exp_controller #(
    parameter int unsigned SIZE = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] input_tdata_base,
    input  logic [SIZE-1:0] input_tdata_exp,
    input  logic [SIZE-1:0] input_tdata_mod,
    input  logic            input_tvalid,
    output logic            input_tready,
    output logic [SIZE-1:0] output_tdata,
    output logic            output_tvalid,
    input  logic            output_tready,
    output logic            output_error,
    output logic [7:0]      op_count,
    output logic            mm_rst,
    output logic [SIZE-1:0] mm_multiplier_tdata,
    output logic [SIZE-1:0] mm_multiplicand_tdata,
    output logic [SIZE-1:0] mm_modulus_tdata,
    output logic            mm_in_tvalid,
    input  logic            mm_in_tready,
    input  logic [SIZE-1:0] mm_out_tdata,
    input  logic            mm_out_tvalid,
    output logic            mm_out_tready
);

    localparam int unsigned IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [3:0] {
        IDLE, SCAN, SQ_ISSUE, SQ_WAIT, SQ_CLR,
        MUL_ISSUE, MUL_WAIT, MUL_CLR, NEXT, DONE
    } state_t;

    state_t            state;
    logic [SIZE-1:0]   base_r;
    logic [SIZE-1:0]   exp_r;
    logic [SIZE-1:0]   mod_r;
    logic [SIZE-1:0]   acc;
    logic [IDX_W-1:0]  bit_idx;
    logic              started;
    logic              cur_bit_c;

    // Exponent bit currently being processed
    assign cur_bit_c = exp_r[bit_idx];

    // Sequencer: job intake, bit scan, multiplier issue/wait/re-arm, result hold
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            input_tready          <= 1'b0;
            output_tdata          <= '0;
            output_tvalid         <= 1'b0;
            output_error          <= 1'b0;
            op_count              <= 8'd0;
            mm_rst                <= 1'b1;
            mm_multiplier_tdata   <= '0;
            mm_multiplicand_tdata <= '0;
            mm_modulus_tdata      <= '0;
            mm_in_tvalid          <= 1'b0;
            mm_out_tready         <= 1'b0;
            base_r                <= '0;
            exp_r                 <= '0;
            mod_r                 <= '0;
            acc                   <= '0;
            bit_idx               <= '0;
            started               <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mm_rst <= 1'b0;
                    if (input_tvalid && input_tready) begin
                        input_tready <= 1'b0;
                        base_r       <= input_tdata_base;
                        exp_r        <= input_tdata_exp;
                        mod_r        <= input_tdata_mod;
                        acc          <= SIZE'(1);
                        bit_idx      <= IDX_W'(SIZE - 1);
                        started      <= 1'b0;
                        op_count     <= 8'd0;
                        if (input_tdata_mod == '0) begin
                            output_tdata  <= '0;
                            output_error  <= 1'b1;
                            output_tvalid <= 1'b1;
                            state         <= DONE;
                        end else if (input_tdata_exp == '0) begin
                            output_tdata  <= (input_tdata_mod == SIZE'(1)) ? '0 : SIZE'(1);
                            output_tvalid <= 1'b1;
                            state         <= DONE;
                        end else begin
                            state <= SCAN;
                        end
                    end else begin
                        input_tready <= 1'b1;
                    end
                end

                SCAN: begin
                    if (started) begin
                        mm_multiplier_tdata   <= acc;
                        mm_multiplicand_tdata <= acc;
                        mm_modulus_tdata      <= mod_r;
                        mm_in_tvalid          <= 1'b1;
                        state                 <= SQ_ISSUE;
                    end else if (cur_bit_c) begin
                        // First set bit: acc is 1, so its squaring is skipped
                        started               <= 1'b1;
                        mm_multiplier_tdata   <= acc;
                        mm_multiplicand_tdata <= base_r;
                        mm_modulus_tdata      <= mod_r;
                        mm_in_tvalid          <= 1'b1;
                        state                 <= MUL_ISSUE;
                    end else begin
                        bit_idx <= bit_idx - IDX_W'(1);
                    end
                end

                SQ_ISSUE, MUL_ISSUE: begin
                    if (mm_in_tready) begin
                        mm_in_tvalid  <= 1'b0;
                        op_count      <= op_count + 8'd1;
                        mm_out_tready <= 1'b1;
                        state         <= (state == SQ_ISSUE) ? SQ_WAIT : MUL_WAIT;
                    end
                end

                SQ_WAIT, MUL_WAIT: begin
                    if (mm_out_tvalid) begin
                        acc           <= mm_out_tdata;
                        mm_out_tready <= 1'b0;
                        mm_rst        <= 1'b1;
                        state         <= (state == SQ_WAIT) ? SQ_CLR : MUL_CLR;
                    end
                end

                SQ_CLR: begin
                    mm_rst <= 1'b0;
                    if (cur_bit_c) begin
                        mm_multiplier_tdata   <= acc;
                        mm_multiplicand_tdata <= base_r;
                        mm_modulus_tdata      <= mod_r;
                        mm_in_tvalid          <= 1'b1;
                        state                 <= MUL_ISSUE;
                    end else begin
                        state <= NEXT;
                    end
                end

                MUL_CLR: begin
                    mm_rst <= 1'b0;
                    state  <= NEXT;
                end

                NEXT: begin
                    if (bit_idx == '0) begin
                        output_tdata  <= acc;
                        output_tvalid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        bit_idx <= bit_idx - IDX_W'(1);
                        state   <= SCAN;
                    end
                end

                DONE: begin
                    if (output_tready) begin
                        output_tvalid <= 1'b0;
                        output_error  <= 1'b0;
                        input_tready  <= 1'b1;
                        state         <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_controller.sv
// tb_mod_exp_controller: directed and random jobs against an arithmetic
// modular-exponentiation model, with a behavioural multiplication_modulo unit.
module tb_mod_exp_controller;

    localparam int unsigned SIZE = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [SIZE-1:0] input_tdata_base = '0;
    logic [SIZE-1:0] input_tdata_exp = '0;
    logic [SIZE-1:0] input_tdata_mod = '0;
    logic            input_tvalid = 1'b0;
    logic            input_tready;
    logic [SIZE-1:0] output_tdata;
    logic            output_tvalid;
    logic            output_tready = 1'b0;
    logic            output_error;
    logic [7:0]      op_count;
    logic            mm_rst;
    logic [SIZE-1:0] mm_multiplier_tdata;
    logic [SIZE-1:0] mm_multiplicand_tdata;
    logic [SIZE-1:0] mm_modulus_tdata;
    logic            mm_in_tvalid;
    logic            mm_in_tready = 1'b0;
    logic [SIZE-1:0] mm_out_tdata = '0;
    logic            mm_out_tvalid = 1'b0;
    logic            mm_out_tready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mod_exp_controller #(.SIZE(SIZE)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .input_tdata_base      (input_tdata_base),
        .input_tdata_exp       (input_tdata_exp),
        .input_tdata_mod       (input_tdata_mod),
        .input_tvalid          (input_tvalid),
        .input_tready          (input_tready),
        .output_tdata          (output_tdata),
        .output_tvalid         (output_tvalid),
        .output_tready         (output_tready),
        .output_error          (output_error),
        .op_count              (op_count),
        .mm_rst                (mm_rst),
        .mm_multiplier_tdata   (mm_multiplier_tdata),
        .mm_multiplicand_tdata (mm_multiplicand_tdata),
        .mm_modulus_tdata      (mm_modulus_tdata),
        .mm_in_tvalid          (mm_in_tvalid),
        .mm_in_tready          (mm_in_tready),
        .mm_out_tdata          (mm_out_tdata),
        .mm_out_tvalid         (mm_out_tvalid),
        .mm_out_tready         (mm_out_tready)
    );

    // Behavioural multiplier: loads once, answers once, then needs mm_rst to re-arm
    typedef enum {U_LOAD, U_COMP, U_OUT, U_USED} uphase_t;
    uphase_t         uph = U_LOAD;
    int unsigned     ucnt = 0;
    logic [SIZE-1:0] ures = '0;

    always @(posedge clk) begin
        if (mm_rst === 1'b1) begin
            uph           <= U_LOAD;
            mm_in_tready  <= 1'b0;
            mm_out_tvalid <= 1'b0;
            mm_out_tdata  <= '0;
            ucnt          <= $urandom_range(0, 3);
        end else begin
            case (uph)
                U_LOAD: begin
                    if (mm_in_tvalid && mm_in_tready) begin
                        mm_in_tready <= 1'b0;
                        uph          <= U_COMP;
                        ucnt         <= $urandom_range(0, 4);
                        ures <= (mm_modulus_tdata == '0) ? '0 :
                            SIZE'(((2*SIZE)'(mm_multiplier_tdata) * (2*SIZE)'(mm_multiplicand_tdata))
                                  % (2*SIZE)'(mm_modulus_tdata));
                    end else if (mm_in_tvalid) begin
                        if (ucnt == 0) mm_in_tready <= 1'b1;
                        else           ucnt <= ucnt - 1;
                    end
                end
                U_COMP: begin
                    if (ucnt == 0) begin
                        mm_out_tvalid <= 1'b1;
                        mm_out_tdata  <= ures;
                        uph           <= U_OUT;
                    end else begin
                        ucnt <= ucnt - 1;
                    end
                end
                U_OUT: begin
                    if (mm_out_tvalid && mm_out_tready) begin
                        mm_out_tvalid <= 1'b0;
                        uph           <= U_USED;
                    end
                end
                default: ;
            endcase
        end
    end

    // Activity counters and operand-stability monitor
    int unsigned     rst_pulses = 0;
    int unsigned     in_valid_cyc = 0;
    int unsigned     stab_err = 0;
    logic            pwait = 1'b0;
    logic [SIZE-1:0] pa = '0, pb = '0, pm = '0;

    always @(posedge clk) begin
        if (rst === 1'b0 && mm_rst === 1'b1) rst_pulses <= rst_pulses + 1;
        if (mm_in_tvalid === 1'b1) in_valid_cyc <= in_valid_cyc + 1;
        if (rst === 1'b0 && pwait && mm_in_tvalid === 1'b1 &&
            (mm_multiplier_tdata !== pa || mm_multiplicand_tdata !== pb || mm_modulus_tdata !== pm))
            stab_err <= stab_err + 1;
        pwait <= (mm_in_tvalid === 1'b1) && (mm_in_tready === 1'b0);
        pa    <= mm_multiplier_tdata;
        pb    <= mm_multiplicand_tdata;
        pm    <= mm_modulus_tdata;
    end

    // Reference: right-to-left exponentiation with wide arithmetic
    function automatic logic [SIZE-1:0] ref_modexp(input logic [SIZE-1:0] b, e, m);
        logic [2*SIZE-1:0] r, x, mw;
        if (m == '0) return '0;
        mw = (2*SIZE)'(m);
        r  = (2*SIZE)'(1) % mw;
        x  = (2*SIZE)'(b) % mw;
        for (int i = 0; i < SIZE; i++) begin
            if (e[i]) r = (r * x) % mw;
            x = (x * x) % mw;
        end
        return SIZE'(r);
    endfunction

    // Reference: one multiply for the top bit, then a square per lower bit plus a multiply per set bit
    function automatic int ref_ops(input logic [SIZE-1:0] e, m);
        int msb, pop;
        msb = 0;
        pop = 0;
        if (m == '0 || e == '0) return 0;
        for (int i = 0; i < SIZE; i++) begin
            if (e[i]) begin
                msb = i;
                pop++;
            end
        end
        return msb + pop;
    endfunction

    task automatic chk(input string tag, input string what, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, expv);
        end
    endtask

    task automatic wait_ready(input string tag);
        int cyc;
        cyc = 0;
        while (input_tready !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, "input_tready", SIZE'(input_tready), SIZE'(1));
    endtask

    task automatic run_job(input string tag, input logic [SIZE-1:0] b, e, m, input int quiet);
        logic [SIZE-1:0] exp_d;
        int              exp_ops;
        int unsigned     p0, v0;
        int              cyc;
        bit              ok;
        exp_d   = ref_modexp(b, e, m);
        exp_ops = ref_ops(e, m);
        wait_ready(tag);
        input_tdata_base = b;
        input_tdata_exp  = e;
        input_tdata_mod  = m;
        input_tvalid     = 1'b1;
        p0 = rst_pulses;
        v0 = in_valid_cyc;
        @(negedge clk);
        input_tvalid = 1'b0;
        chk(tag, "ready_low", SIZE'(input_tready), SIZE'(0));
        ok = 1'b1;
        for (int i = 0; i < quiet; i++) begin
            if (mm_in_tvalid !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        if (quiet > 0) chk(tag, "no_issue_during_leading_zeros", SIZE'(ok), SIZE'(1));
        cyc = 0;
        while (output_tvalid !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, "output_tvalid", SIZE'(output_tvalid), SIZE'(1));
        chk(tag, "output_tdata", output_tdata, exp_d);
        chk(tag, "output_error", SIZE'(output_error), SIZE'(m == '0));
        chk(tag, "op_count", SIZE'(op_count), SIZE'(exp_ops));
        chk(tag, "mm_rst_pulses", SIZE'(rst_pulses - p0), SIZE'(exp_ops));
        if (exp_ops == 0) chk(tag, "mm_in_tvalid_cycles", SIZE'(in_valid_cyc - v0), SIZE'(0));
    endtask

    task automatic drain(input string tag);
        output_tready = 1'b1;
        @(negedge clk);
        output_tready = 1'b0;
        chk(tag, "tvalid_cleared", SIZE'(output_tvalid), SIZE'(0));
        chk(tag, "error_cleared", SIZE'(output_error), SIZE'(0));
    endtask

    task automatic check_reset_values(input string tag);
        chk(tag, "input_tready", SIZE'(input_tready), SIZE'(0));
        chk(tag, "output_tvalid", SIZE'(output_tvalid), SIZE'(0));
        chk(tag, "output_tdata", output_tdata, '0);
        chk(tag, "output_error", SIZE'(output_error), SIZE'(0));
        chk(tag, "op_count", SIZE'(op_count), SIZE'(0));
        chk(tag, "mm_rst", SIZE'(mm_rst), SIZE'(1));
        chk(tag, "mm_in_tvalid", SIZE'(mm_in_tvalid), SIZE'(0));
        chk(tag, "mm_out_tready", SIZE'(mm_out_tready), SIZE'(0));
        chk(tag, "operand_a", mm_multiplier_tdata, '0);
        chk(tag, "operand_b", mm_multiplicand_tdata, '0);
        chk(tag, "operand_m", mm_modulus_tdata, '0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SIZE-1:0] rb, re, rm;
        int              cyc;
        int              sel;

        // Power-on reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Basic job, then 63 leading zeros
        run_job("3^5%7", SIZE'(3), SIZE'(5), SIZE'(7), 0);
        drain("3^5%7");
        run_job("10^1%7", SIZE'(10), SIZE'(1), SIZE'(7), 63);
        drain("10^1%7");

        // Zero exponent, and modulus 1
        run_job("5^0%13", SIZE'(5), SIZE'(0), SIZE'(13), 0);
        drain("5^0%13");
        run_job("5^0%1", SIZE'(5), SIZE'(0), SIZE'(1), 0);
        drain("5^0%1");

        // Zero modulus reports an error, next job is clean
        run_job("mod0", SIZE'(64'h1234_5678), SIZE'(9), SIZE'(0), 0);
        drain("mod0");
        run_job("2^10%1000", SIZE'(2), SIZE'(10), SIZE'(1000), 0);
        drain("2^10%1000");

        // Output backpressure
        run_job("bp", SIZE'(3), SIZE'(5), SIZE'(7), 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp", "tvalid_held", SIZE'(output_tvalid), SIZE'(1));
            chk("bp", "tdata_held", output_tdata, SIZE'(5));
            chk("bp", "input_tready_low", SIZE'(input_tready), SIZE'(0));
        end
        drain("bp");

        // Reset while waiting on a squaring result
        wait_ready("abort");
        input_tdata_base = SIZE'(2);
        input_tdata_exp  = SIZE'(64'hFFFF);
        input_tdata_mod  = SIZE'(65521);
        input_tvalid     = 1'b1;
        @(negedge clk);
        input_tvalid = 1'b0;
        cyc = 0;
        while (!(mm_out_tready === 1'b1 && op_count >= 8'd2) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort", "reached_sq_wait", SIZE'(mm_out_tready === 1'b1 && op_count == 8'd2), SIZE'(1));
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("abort");
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (output_tvalid !== 1'b0) cyc++;
        end
        chk("abort", "no_partial_result", SIZE'(cyc), SIZE'(0));
        run_job("after_abort", SIZE'(3), SIZE'(5), SIZE'(7), 0);
        drain("after_abort");

        // Random jobs
        for (int j = 0; j < 12; j++) begin
            rb  = {$urandom, $urandom};
            re  = {$urandom, $urandom};
            re  = re >> $urandom_range(0, 63);
            sel = $urandom_range(0, 9);
            if (sel == 0)      rm = '0;
            else if (sel == 1) rm = SIZE'(1);
            else if (sel < 5)  rm = SIZE'($urandom_range(2, 1000));
            else               rm = {$urandom, $urandom};
            run_job($sformatf("rand%0d", j), rb, re, rm, 0);
            drain($sformatf("rand%0d", j));
        end

        chk("mm", "operands_stable_while_waiting", SIZE'(stab_err), SIZE'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
